// File: rtl/rs_pkg.sv
// Shared defaults, entry status layout and FU-class tagging for the reservation stations.
package rs_pkg;

    localparam int unsigned TagWDefault     = 6;
    localparam int unsigned PayloadWDefault = 64;

    // Per-entry status bits; tags and payload are stored alongside as separate fields.
    typedef struct packed {
        logic valid;
        logic prs1_rdy;
        logic prs2_rdy;
    } rs_status_t;

    typedef enum logic [1:0] {
        FuAlu = 2'd0,
        FuMul = 2'd1,
        FuLsu = 2'd2
    } fu_class_e;

endpackage

// File: rtl/rs_unit_entry.sv
// One reservation-station slot: operand tags, payload and CDB wakeup of the two sources.
module rs_unit_entry
    import rs_pkg::*;
#(
    parameter int unsigned TAG_W     = TagWDefault,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned PAYLOAD_W = PayloadWDefault
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     alloc_sel_i,
    input  logic                     issue_sel_i,
    input  logic [PAYLOAD_W-1:0]     alloc_payload_i,
    input  logic [TAG_W-1:0]         alloc_prs1_i,
    input  logic [TAG_W-1:0]         alloc_prs2_i,
    input  logic [TAG_W-1:0]         alloc_prd_i,
    input  logic                     alloc_prs1_rdy_i,
    input  logic                     alloc_prs2_rdy_i,
    input  logic [NUM_CDB-1:0]       cdb_en_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    output logic                     valid_o,
    output logic                     ready_o,
    output logic [PAYLOAD_W-1:0]     payload_o,
    output logic [TAG_W-1:0]         prs1_o,
    output logic [TAG_W-1:0]         prs2_o,
    output logic [TAG_W-1:0]         prd_o
);

    rs_status_t           status_q, status_d;
    logic [TAG_W-1:0]     prs1_q, prs1_d, prs2_q, prs2_d, prd_q, prd_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    function automatic logic cdb_hit(input logic [TAG_W-1:0]         tag,
                                     input logic [NUM_CDB-1:0]       en,
                                     input logic [NUM_CDB*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            hit |= en[k] & (tags[k*TAG_W +: TAG_W] == tag);
        end
        return hit;
    endfunction

    always_comb begin
        status_d  = status_q;
        prs1_d    = prs1_q;
        prs2_d    = prs2_q;
        prd_d     = prd_q;
        payload_d = payload_q;
        if (alloc_sel_i) begin
            // Snooping the CDB on the alloc tags closes the dispatch/broadcast race.
            status_d.valid    = 1'b1;
            status_d.prs1_rdy = alloc_prs1_rdy_i | cdb_hit(alloc_prs1_i, cdb_en_i, cdb_tag_i);
            status_d.prs2_rdy = alloc_prs2_rdy_i | cdb_hit(alloc_prs2_i, cdb_en_i, cdb_tag_i);
            prs1_d            = alloc_prs1_i;
            prs2_d            = alloc_prs2_i;
            prd_d             = alloc_prd_i;
            payload_d         = alloc_payload_i;
        end else if (status_q.valid) begin
            status_d.prs1_rdy = status_q.prs1_rdy | cdb_hit(prs1_q, cdb_en_i, cdb_tag_i);
            status_d.prs2_rdy = status_q.prs2_rdy | cdb_hit(prs2_q, cdb_en_i, cdb_tag_i);
            if (issue_sel_i) begin
                status_d.valid = 1'b0;
            end
        end
        if (flush_i) begin
            status_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            status_q  <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            prd_q     <= '0;
            payload_q <= '0;
        end else begin
            status_q  <= status_d;
            prs1_q    <= prs1_d;
            prs2_q    <= prs2_d;
            prd_q     <= prd_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = status_q.valid;
    assign ready_o   = status_q.valid & status_q.prs1_rdy & status_q.prs2_rdy;
    assign payload_o = payload_q;
    assign prs1_o    = prs1_q;
    assign prs2_o    = prs2_q;
    assign prd_o     = prd_q;

endmodule

// File: rtl/rs_unit.sv
// Reservation station: lowest-free-slot allocation, CDB wakeup and oldest-ready issue
// selected through an older-than matrix.
module rs_unit
    import rs_pkg::*;
#(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned TAG_W     = TagWDefault,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned PAYLOAD_W = PayloadWDefault,
    localparam int unsigned CntW     = $clog2(RS_SIZE + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [PAYLOAD_W-1:0]     alloc_payload_i,
    input  logic [TAG_W-1:0]         alloc_prs1_i,
    input  logic [TAG_W-1:0]         alloc_prs2_i,
    input  logic [TAG_W-1:0]         alloc_prd_i,
    input  logic                     alloc_prs1_rdy_i,
    input  logic                     alloc_prs2_rdy_i,
    input  logic [NUM_CDB-1:0]       cdb_en_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [PAYLOAD_W-1:0]     issue_payload_o,
    output logic [TAG_W-1:0]         issue_prs1_o,
    output logic [TAG_W-1:0]         issue_prs2_o,
    output logic [TAG_W-1:0]         issue_prd_o,
    output logic [CntW-1:0]          count_o,
    output logic                     empty_o
);

    logic [RS_SIZE-1:0]   ent_valid, ent_ready, free_oh, alloc_sel, issue_sel, sel_oh;
    logic [PAYLOAD_W-1:0] ent_payload [RS_SIZE];
    logic [TAG_W-1:0]     ent_prs1 [RS_SIZE];
    logic [TAG_W-1:0]     ent_prs2 [RS_SIZE];
    logic [TAG_W-1:0]     ent_prd [RS_SIZE];
    // older_q[i][k] set means entry k is older than entry i.
    logic [RS_SIZE-1:0]   older_q [RS_SIZE];
    logic [RS_SIZE-1:0]   older_d [RS_SIZE];
    logic [CntW-1:0]      count_q, count_d;
    logic                 alloc_fire, issue_fire, found;

    assign alloc_ready_o = (count_q != CntW'(RS_SIZE));
    assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;
    assign issue_fire    = issue_valid_o & issue_ready_i & ~flush_i;
    assign alloc_sel     = free_oh & {RS_SIZE{alloc_fire}};
    assign issue_sel     = sel_oh & {RS_SIZE{issue_fire}};

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
        rs_unit_entry #(
            .TAG_W     (TAG_W),
            .NUM_CDB   (NUM_CDB),
            .PAYLOAD_W (PAYLOAD_W)
        ) u_entry (
            .clk_i            (clk_i),
            .reset_i          (reset_i),
            .flush_i          (flush_i),
            .alloc_sel_i      (alloc_sel[g]),
            .issue_sel_i      (issue_sel[g]),
            .alloc_payload_i  (alloc_payload_i),
            .alloc_prs1_i     (alloc_prs1_i),
            .alloc_prs2_i     (alloc_prs2_i),
            .alloc_prd_i      (alloc_prd_i),
            .alloc_prs1_rdy_i (alloc_prs1_rdy_i),
            .alloc_prs2_rdy_i (alloc_prs2_rdy_i),
            .cdb_en_i         (cdb_en_i),
            .cdb_tag_i        (cdb_tag_i),
            .valid_o          (ent_valid[g]),
            .ready_o          (ent_ready[g]),
            .payload_o        (ent_payload[g]),
            .prs1_o           (ent_prs1[g]),
            .prs2_o           (ent_prs2[g]),
            .prd_o            (ent_prd[g])
        );
    end

    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!ent_valid[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Stale bits of freed slots are harmless: a column is cleared before its slot can be ready.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            older_d[i] = alloc_sel[i] ? ent_valid : (older_q[i] & ~alloc_sel);
        end
    end

    always_comb begin
        sel_oh          = '0;
        issue_payload_o = '0;
        issue_prs1_o    = '0;
        issue_prs2_o    = '0;
        issue_prd_o     = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            sel_oh[i]        = ent_ready[i] & ~|(ent_ready & older_q[i]);
            issue_payload_o |= ent_payload[i] & {PAYLOAD_W{sel_oh[i]}};
            issue_prs1_o    |= ent_prs1[i] & {TAG_W{sel_oh[i]}};
            issue_prs2_o    |= ent_prs2[i] & {TAG_W{sel_oh[i]}};
            issue_prd_o     |= ent_prd[i] & {TAG_W{sel_oh[i]}};
        end
    end

    assign issue_valid_o = |ent_ready;

    always_comb begin
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(alloc_fire) - CntW'(issue_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_rs_unit.sv
// Directed bench for rs_unit: in-order issue, wakeup, alloc-time CDB snoop, full, age, flush.
module tb_rs_unit;

    logic        clk_i = 1'b0;
    logic        reset_i, flush_i, alloc_valid_i, alloc_ready_o;
    logic [63:0] alloc_payload_i, issue_payload_o;
    logic [5:0]  alloc_prs1_i, alloc_prs2_i, alloc_prd_i;
    logic        alloc_prs1_rdy_i, alloc_prs2_rdy_i;
    logic [1:0]  cdb_en_i;
    logic [11:0] cdb_tag_i;
    logic        issue_valid_o, issue_ready_i, empty_o;
    logic [5:0]  issue_prs1_o, issue_prs2_o, issue_prd_o;
    logic [3:0]  count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rs_unit u_dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_payload_i  (alloc_payload_i),
        .alloc_prs1_i     (alloc_prs1_i),
        .alloc_prs2_i     (alloc_prs2_i),
        .alloc_prd_i      (alloc_prd_i),
        .alloc_prs1_rdy_i (alloc_prs1_rdy_i),
        .alloc_prs2_rdy_i (alloc_prs2_rdy_i),
        .cdb_en_i         (cdb_en_i),
        .cdb_tag_i        (cdb_tag_i),
        .issue_valid_o    (issue_valid_o),
        .issue_ready_i    (issue_ready_i),
        .issue_payload_o  (issue_payload_o),
        .issue_prs1_o     (issue_prs1_o),
        .issue_prs2_o     (issue_prs2_o),
        .issue_prd_o      (issue_prd_o),
        .count_o          (count_o),
        .empty_o          (empty_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input logic [63:0] pl, input logic [5:0] s1, input logic r1,
                         input logic [5:0] s2, input logic r2, input logic [5:0] rd);
        alloc_valid_i    = 1'b1;
        alloc_payload_i  = pl;
        alloc_prs1_i     = s1;
        alloc_prs1_rdy_i = r1;
        alloc_prs2_i     = s2;
        alloc_prs2_rdy_i = r2;
        alloc_prd_i      = rd;
    endtask

    task automatic quiet();
        alloc_valid_i = 1'b0;
        cdb_en_i      = 2'b00;
        cdb_tag_i     = '0;
        flush_i       = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0;
        issue_ready_i = 1'b0;
        alloc_payload_i = '0;
        alloc_prs1_i = '0;
        alloc_prs2_i = '0;
        alloc_prd_i = '0;
        alloc_prs1_rdy_i = 1'b0;
        alloc_prs2_rdy_i = 1'b0;
        quiet();
        tick();
        tick();
        reset_i = 1'b1;
        check("rst_iv", 64'(issue_valid_o), 64'd0);
        check("rst_cnt", 64'(count_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_ardy", 64'(alloc_ready_o), 64'd1);
        check("rst_pl", issue_payload_o, 64'd0);

        // Three ready entries issue in allocation order.
        alloc(64'hA0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40);
        tick();
        check("ord_cnt1", 64'(count_o), 64'd1);
        check("ord_pl_a", issue_payload_o, 64'hA0);
        check("ord_prd_a", 64'(issue_prd_o), 64'd40);
        alloc(64'hA1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd41);
        tick();
        check("ord_cnt2", 64'(count_o), 64'd2);
        check("ord_pl_a2", issue_payload_o, 64'hA0);
        alloc(64'hA2, 6'd1, 1'b1, 6'd2, 1'b1, 6'd42);
        issue_ready_i = 1'b1;
        tick();
        quiet();
        check("ord_cnt3", 64'(count_o), 64'd2);
        check("ord_pl_b", issue_payload_o, 64'hA1);
        tick();
        check("ord_cnt4", 64'(count_o), 64'd1);
        check("ord_pl_c", issue_payload_o, 64'hA2);
        tick();
        check("ord_cnt5", 64'(count_o), 64'd0);
        check("ord_iv0", 64'(issue_valid_o), 64'd0);
        issue_ready_i = 1'b0;

        // Waiting entry A is bypassed by ready B; A becomes eligible the cycle after its wakeup.
        alloc(64'h0A, 6'd5, 1'b0, 6'd3, 1'b1, 6'd50);
        tick();
        check("wk_iv0", 64'(issue_valid_o), 64'd0);
        alloc(64'h0B, 6'd7, 1'b1, 6'd8, 1'b1, 6'd51);
        tick();
        quiet();
        check("wk_pl_b", issue_payload_o, 64'h0B);
        cdb_en_i = 2'b01;
        cdb_tag_i = {6'd0, 6'd5};
        issue_ready_i = 1'b1;
        tick();
        quiet();
        check("wk_cnt", 64'(count_o), 64'd1);
        check("wk_pl_a", issue_payload_o, 64'h0A);
        check("wk_prs1", 64'(issue_prs1_o), 64'd5);
        tick();
        check("wk_cnt0", 64'(count_o), 64'd0);
        issue_ready_i = 1'b0;

        // Broadcast of prs2 on port 1 in the alloc cycle marks it ready immediately.
        alloc(64'hC3, 6'd4, 1'b1, 6'd9, 1'b0, 6'd52);
        cdb_en_i = 2'b10;
        cdb_tag_i = {6'd9, 6'd0};
        tick();
        quiet();
        check("race_iv", 64'(issue_valid_o), 64'd1);
        check("race_prs2", 64'(issue_prs2_o), 64'd9);
        issue_ready_i = 1'b1;
        tick();
        check("race_cnt", 64'(count_o), 64'd0);
        issue_ready_i = 1'b0;

        // Fill with waiting entries; a further alloc is dropped.
        for (int i = 0; i < 8; i++) begin
            alloc(64'h100 + 64'(i), 6'(10 + i), 1'b0, 6'd2, 1'b1, 6'(i));
            tick();
        end
        check("full_cnt", 64'(count_o), 64'd8);
        check("full_ardy", 64'(alloc_ready_o), 64'd0);
        check("full_iv", 64'(issue_valid_o), 64'd0);
        alloc(64'hDEAD, 6'd1, 1'b1, 6'd2, 1'b1, 6'd60);
        tick();
        quiet();
        check("full_drop", 64'(count_o), 64'd8);
        cdb_en_i = 2'b01;
        cdb_tag_i = {6'd0, 6'd13};
        tick();
        quiet();
        check("full_pl3", issue_payload_o, 64'h103);
        check("full_ardy2", 64'(alloc_ready_o), 64'd0);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        check("full_cnt7", 64'(count_o), 64'd7);
        check("full_ardy3", 64'(alloc_ready_o), 64'd1);
        flush_i = 1'b1;
        tick();
        quiet();
        check("clr_cnt", 64'(count_o), 64'd0);

        // Slot 2 freed and refilled with the youngest entry; age, not index, picks 3, 5, 2.
        for (int i = 0; i < 6; i++) begin
            alloc(64'h50 + 64'(i), 6'(20 + i), 1'b0, 6'd2, 1'b1, 6'(i));
            tick();
        end
        quiet();
        cdb_en_i = 2'b01;
        cdb_tag_i = {6'd0, 6'd22};
        tick();
        quiet();
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        check("age_cnt5", 64'(count_o), 64'd5);
        alloc(64'h77, 6'd30, 1'b0, 6'd2, 1'b1, 6'd33);
        tick();
        quiet();
        cdb_en_i = 2'b11;
        cdb_tag_i = {6'd25, 6'd23};
        tick();
        quiet();
        cdb_en_i = 2'b11;
        cdb_tag_i = {6'd30, 6'd30};
        tick();
        quiet();
        check("age_first", issue_payload_o, 64'h53);
        issue_ready_i = 1'b1;
        tick();
        check("age_second", issue_payload_o, 64'h55);
        tick();
        check("age_third", issue_payload_o, 64'h77);
        check("age_prd", 64'(issue_prd_o), 64'd33);
        tick();
        issue_ready_i = 1'b0;
        check("age_cnt3", 64'(count_o), 64'd3);

        // Flush at count 4 with an issuable entry and a pending alloc.
        alloc(64'h88, 6'd1, 1'b1, 6'd2, 1'b1, 6'd34);
        cdb_en_i = 2'b01;
        cdb_tag_i = {6'd0, 6'd20};
        tick();
        quiet();
        check("fl_cnt4", 64'(count_o), 64'd4);
        alloc(64'h99, 6'd1, 1'b1, 6'd2, 1'b1, 6'd35);
        flush_i = 1'b1;
        issue_ready_i = 1'b1;
        tick();
        quiet();
        issue_ready_i = 1'b0;
        check("fl_cnt", 64'(count_o), 64'd0);
        check("fl_empty", 64'(empty_o), 64'd1);
        check("fl_iv", 64'(issue_valid_o), 64'd0);
        tick();
        check("fl_hold", 64'(count_o), 64'd0);

        // Reset in the middle of traffic.
        alloc(64'hE0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd36);
        tick();
        tick();
        check("mr_cnt2", 64'(count_o), 64'd2);
        reset_i = 1'b0;
        issue_ready_i = 1'b1;
        tick();
        reset_i = 1'b1;
        quiet();
        issue_ready_i = 1'b0;
        check("mr_cnt", 64'(count_o), 64'd0);
        check("mr_iv", 64'(issue_valid_o), 64'd0);
        check("mr_empty", 64'(empty_o), 64'd1);
        check("mr_ardy", 64'(alloc_ready_o), 64'd1);
        check("mr_pl", issue_payload_o, 64'd0);
        check("mr_prd", 64'(issue_prd_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
